// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory controller:
// FSM state encoding, fill pattern bytes and a lane-select width helper.
package data_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    FILL  = 2'd2
  } state_t;

  localparam logic [7:0] PAT_ONES  = 8'hFF;
  localparam logic [7:0] PAT_ZEROS = 8'h00;
  localparam logic [7:0] PAT_F0    = 8'hF0;
  localparam logic [7:0] PAT_AA    = 8'hAA;

  // Byte value written to every lane during a fill, keyed by Pattern_Sel.
  function automatic logic [7:0] pattern_byte(input logic [1:0] sel);
    case (sel)
      2'b00:   return PAT_ONES;
      2'b01:   return PAT_ZEROS;
      2'b10:   return PAT_F0;
      default: return PAT_AA;
    endcase
  endfunction

  // Width of the LED lane selector; never narrower than one bit.
  function automatic int lane_sel_w(input int data_w, input int led_w);
    return (data_w / led_w > 1) ? $clog2(data_w / led_w) : 1;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Host-side bus of the data memory controller.
// Optional macro DATA_MEM_PARITY_EN adds the parity_err response signal.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int LED_W  = 8
);
  import data_mem_pkg::*;

  localparam int LANE_SEL_W = lane_sel_w(DATA_W, LED_W);

  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_write;
  logic                  mem_read;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     w_data;
  logic                  fill_start;
  logic [1:0]            pattern_sel;
  logic [LANE_SEL_W-1:0] lane_sel;
  logic [DATA_W-1:0]     r_data;
  logic                  r_valid;
  logic                  busy;
  logic [LED_W-1:0]      led;
`ifdef DATA_MEM_PARITY_EN
  logic                  parity_err;
`endif

  modport master (
    output mem_addr, mem_write, mem_read, byte_en, w_data,
    output fill_start, pattern_sel, lane_sel,
`ifdef DATA_MEM_PARITY_EN
    input  parity_err,
`endif
    input  r_data, r_valid, busy, led
  );

  modport slave (
    input  mem_addr, mem_write, mem_read, byte_en, w_data,
    input  fill_start, pattern_sel, lane_sel,
`ifdef DATA_MEM_PARITY_EN
    output parity_err,
`endif
    output r_data, r_valid, busy, led
  );

endinterface

// File: rtl/data_mem_array.sv
// Simple-dual-port RAM (one write port with lane enables, one registered
// read port). Contents are never reset; only the read register is.
module data_mem_array #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [LANES-1:0]        wbe,
  input  logic [LANES*LANE_W-1:0] wdata,
  input  logic                    re,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [LANES*LANE_W-1:0] rdata
);

  logic [LANES*LANE_W-1:0] mem [2**ADDR_W];

  // Lane-masked write; a same-address read in this edge still sees old data.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wbe[i]) mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // Registered read that holds its value between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: clears the array after reset, serves host
// byte-masked writes and 1-cycle reads when idle, performs whole-array
// pattern fills and drives an LED slice of the last read word.
// Optional macro DATA_MEM_PARITY_EN stores an even-parity bit per byte and
// flags mismatches on reads through parity_err.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int LED_W  = 8
) (
  input logic           clk,
  input logic           rst,
  data_mem_ctrl_if.slave bus
);

  localparam int BYTES = DATA_W / 8;
`ifdef DATA_MEM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cnt_reg, cnt_next;
  logic [1:0]          pat_reg, pat_next;
  logic                r_valid_reg;
  logic [LED_W-1:0]    led_reg;

  logic                we, re;
  logic [ADDR_W-1:0]   waddr;
  logic [BYTES-1:0]    wbe;
  logic [DATA_W-1:0]   wdata;
  logic [BYTES*LANE_W-1:0] ram_wdata, ram_rdata;
  logic [DATA_W-1:0]   rd_word;

  // State, sweep counter, latched pattern, read strobe and LED register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= CLEAR;
      cnt_reg     <= '0;
      pat_reg     <= 2'b00;
      r_valid_reg <= 1'b0;
      led_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pat_reg     <= pat_next;
      r_valid_reg <= re;
      led_reg     <= rd_word[int'(bus.lane_sel)*LED_W +: LED_W];
    end
  end

  // Next state and write/read port steering; host traffic only in IDLE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pat_next   = pat_reg;
    we         = 1'b0;
    re         = 1'b0;
    waddr      = cnt_reg;
    wbe        = '1;
    wdata      = '0;
    case (state_reg)
      CLEAR: begin
        we       = 1'b1;
        cnt_next = cnt_reg + ADDR_W'(1);
        if (cnt_reg == ADDR_LAST) state_next = IDLE;
      end
      FILL: begin
        we       = 1'b1;
        wdata    = {BYTES{pattern_byte(pat_reg)}};
        cnt_next = cnt_reg + ADDR_W'(1);
        if (cnt_reg == ADDR_LAST) state_next = IDLE;
      end
      default: begin
        we    = bus.mem_write;
        re    = bus.mem_read;
        waddr = bus.mem_addr;
        wbe   = bus.byte_en;
        wdata = bus.w_data;
        if (bus.fill_start) begin
          pat_next   = bus.pattern_sel;
          cnt_next   = '0;
          state_next = FILL;
        end
      end
    endcase
  end

`ifdef DATA_MEM_PARITY_EN
  logic [BYTES-1:0] lane_err;
`endif

  // Map data bytes (plus optional parity bit) onto RAM lanes.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    assign ram_wdata[gi*LANE_W +: 8] = wdata[gi*8 +: 8];
    assign rd_word[gi*8 +: 8]        = ram_rdata[gi*LANE_W +: 8];
`ifdef DATA_MEM_PARITY_EN
    assign ram_wdata[gi*LANE_W + 8]  = ^wdata[gi*8 +: 8];
    assign lane_err[gi]              = ^ram_rdata[gi*LANE_W +: 9];
`endif
  end

  data_mem_array #(
    .LANES  (BYTES),
    .LANE_W (LANE_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wbe   (wbe),
    .wdata (ram_wdata),
    .re    (re),
    .raddr (bus.mem_addr),
    .rdata (ram_rdata)
  );

  assign bus.r_data  = rd_word;
  assign bus.r_valid = r_valid_reg;
  assign bus.busy    = (state_reg != IDLE);
  assign bus.led     = led_reg;
`ifdef DATA_MEM_PARITY_EN
  assign bus.parity_err = r_valid_reg & (|lane_err);
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: stimulus pushes expected read words
// taken from a word-array reference model; a monitor pops on every r_valid.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_ctrl_if bus ();

  data_mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [64];
  logic [31:0] exp_q [$];
  logic [31:0] last_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat_word(input logic [1:0] ps);
    case (ps)
      2'd0:    return 32'hFFFF_FFFF;
      2'd1:    return 32'h0000_0000;
      2'd2:    return 32'hF0F0_F0F0;
      default: return 32'hAAAA_AAAA;
    endcase
  endfunction

  // Monitor: pop on each read strobe, otherwise check r_data holds.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        last_rdata = 32'h0;
      end else if (bus.r_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_r_valid: got r_data %h with no read pending", bus.r_data);
        end else begin
          e = exp_q.pop_front();
          check("read_data", bus.r_data, e);
          last_rdata = e;
        end
`ifdef DATA_MEM_PARITY_EN
        check("parity_err", {31'b0, bus.parity_err}, 32'h0);
`endif
      end else begin
        check("r_data_hold", bus.r_data, last_rdata);
      end
    end
  end

  task automatic idle_inputs();
    bus.mem_write   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.fill_start  = 1'b0;
    bus.mem_addr    = '0;
    bus.byte_en     = '0;
    bus.w_data      = '0;
    bus.pattern_sel = '0;
  endtask

  // One host cycle, called at a negedge; returns at the following negedge.
  task automatic op(input bit wr, input bit rd, input logic [5:0] addr,
                    input logic [3:0] be, input logic [31:0] wd,
                    input bit fs, input logic [1:0] ps, input bit exp_busy);
    check("busy_before_op", {31'b0, bus.busy}, {31'b0, exp_busy});
    bus.mem_write   = wr;
    bus.mem_read    = rd;
    bus.mem_addr    = addr;
    bus.byte_en     = be;
    bus.w_data      = wd;
    bus.fill_start  = fs;
    bus.pattern_sel = ps;
    if (!exp_busy) begin
      if (rd) exp_q.push_back(model[addr]);
      if (wr) for (int b = 0; b < 4; b++) if (be[b]) model[addr][8*b +: 8] = wd[8*b +: 8];
      if (fs) for (int a = 0; a < 64; a++) model[a] = pat_word(ps);
    end
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic rd_op(input logic [5:0] addr);
    op(1'b0, 1'b1, addr, 4'h0, 32'h0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic wr_op(input logic [5:0] addr, input logic [3:0] be, input logic [31:0] wd);
    op(1'b1, 1'b0, addr, be, wd, 1'b0, 2'd0, 1'b0);
  endtask

  // Count busy-high negedges (bounded) and compare against the expected length.
  task automatic wait_idle(input string name, input int expected);
    int n = 0;
    while (bus.busy && n < 500) begin
      n++;
      @(negedge clk);
    end
    check(name, n, expected);
  endtask

  // Assert reset at the current time, check reset outputs, release.
  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_r_data", bus.r_data, 32'h0);
    check("rst_r_valid", {31'b0, bus.r_valid}, 32'h0);
    check("rst_led", {24'b0, bus.led}, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 64; a++) model[a] = 32'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [5:0]  a;
    logic [31:0] w;
    int          r;
    idle_inputs();
    bus.lane_sel = '0;
    @(negedge clk);
    do_reset();
    wait_idle("reset_busy_cycles", 64);

    // Cleared array, top address.
    rd_op(6'd63);

    // Byte-masked write over zeros.
    wr_op(6'd5, 4'b0101, 32'h1234_5678);
    rd_op(6'd5);
    check("byte_write_word", bus.r_data, 32'h0034_0078);

    // Fill with F0 pattern; a write during the fill is ignored.
    op(1'b0, 1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 2'b10, 1'b0);
    op(1'b1, 1'b0, 6'd0, 4'hF, 32'h1234_5678, 1'b0, 2'd0, 1'b1);
    wait_idle("fill_busy_cycles", 63);
    rd_op(6'd0);
    check("fill_addr0", bus.r_data, 32'hF0F0_F0F0);
    rd_op(6'd63);

    // Same-address read/write collision returns old contents.
    wr_op(6'd9, 4'hF, 32'hAAAA_AAAA);
    op(1'b1, 1'b1, 6'd9, 4'hF, 32'h1111_1111, 1'b0, 2'd0, 1'b0);
    check("collision_old", bus.r_data, 32'hAAAA_AAAA);
    rd_op(6'd9);

    // LED lane sweep over the last read word.
    wr_op(6'd12, 4'hF, 32'hF0F0_A5C3);
    rd_op(6'd12);
    for (int l = 0; l < 4; l++) begin
      bus.lane_sel = 2'(l);
      @(negedge clk);
      check($sformatf("led_lane%0d", l), {24'b0, bus.led}, (model[12] >> (8*l)) & 32'hFF);
    end
    bus.lane_sel = '0;

    // Fill starting in the same cycle as a host read and write.
    op(1'b1, 1'b1, 6'd20, 4'hF, 32'h5555_1234, 1'b1, 2'b11, 1'b0);
    wait_idle("fill_collide_cycles", 64);
    rd_op(6'd20);
    rd_op(6'd33);

    // Randomised traffic with occasional fills.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 39));
      a = 6'($urandom_range(0, 63));
      w = $urandom;
      if (r == 0) begin
        op(1'($urandom), 1'($urandom), a, 4'($urandom), w, 1'b1, 2'($urandom), 1'b0);
        wait_idle("random_fill_cycles", 64);
      end else begin
        op(1'($urandom), 1'($urandom), a, 4'($urandom), w, 1'b0, 2'd0, 1'b0);
      end
    end

    // Reset in the middle of a fill (fill counter at 20).
    op(1'b0, 1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 2'b00, 1'b0);
    repeat (20) @(negedge clk);
    do_reset();
    wait_idle("midfill_reset_busy", 64);
    for (int i = 0; i < 64; i++) rd_op(6'(i));

    repeat (3) @(negedge clk);
    check("pending_reads", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning the word address width; depth is 2**ADDR_W.
REQ-003 The block SHALL have parameter LED_W, default 8, meaning the width of the display lane.
REQ-004 Clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Rst  input  1  asynchronous, active-high reset.
REQ-006 Mem_Addr  input  ADDR_W  word address for a host access.
REQ-007 Mem_Write  input  1  host write request for one cycle.
REQ-008 Mem_Read  input  1  host read request for one cycle.
REQ-009 Byte_En  input  DATA_W/8  per-byte write enable.
REQ-010 W_Data  input  DATA_W  write data.
REQ-011 Fill_Start  input  1  start a whole-array pattern fill.
REQ-012 Pattern_Sel  input  2  fill pattern: 00 all ones, 01 all zeros, 10 F0-repeat, 11 A-repeat.
REQ-013 Lane_Sel  input  log2(DATA_W/LED_W)  selects the LED_W slice of the last read word.
REQ-014 R_Data  output  DATA_W  read data.
REQ-015 R_Valid  output  1  one-cycle strobe when R_Data is new.
REQ-016 Busy  output  1  high while a clear or fill is in progress.
REQ-017 LED  output  LED_W  registered slice of the last read word, selected by Lane_Sel.

Function
REQ-018 The FSM SHALL have the states CLEAR, IDLE and FILL; it SHALL enter CLEAR on reset.
REQ-019 CLEAR SHALL write all zeros to one address per cycle, from address 0 up to 2**ADDR_W-1, then go to IDLE; it takes 2**ADDR_W cycles.
REQ-020 In IDLE, a Fill_Start pulse SHALL latch Pattern_Sel and move the FSM to FILL.
REQ-021 FILL SHALL write the latched pattern to every byte of one address per cycle, ascending, then return to IDLE.
REQ-022 Busy SHALL be high in CLEAR and FILL and low in IDLE.
REQ-023 Host Mem_Write, Mem_Read and Fill_Start SHALL be ignored while Busy is high; no error and no queueing.
REQ-024 An IDLE write SHALL update only the bytes whose Byte_En bit is set, in the same edge.
REQ-025 An IDLE read SHALL have 1-cycle latency: R_Data and R_Valid are valid on the edge after the request.
REQ-026 R_Data SHALL hold its value until the next read.
REQ-027 If Mem_Write and Mem_Read target the same address in the same cycle, the read SHALL return the pre-write contents.
REQ-028 If Fill_Start coincides with a host access in IDLE, the host access SHALL complete and the fill SHALL start that same edge.
REQ-029 LED SHALL update on the edge after R_Valid or after a Lane_Sel change, from the held R_Data.
REQ-030 The address counter SHALL wrap to 0 on exiting CLEAR or FILL.

Reset
REQ-031 On Rst high: FSM=CLEAR, counter=0, R_Data=0, R_Valid=0, LED=0, Busy=1, latched pattern=00.
REQ-032 Rst asserted mid-fill SHALL abandon the fill and restart CLEAR from address 0 after release.

Configuration
REQ-033 With macro DATA_MEM_PARITY_EN defined, the block SHALL store one even-parity bit per byte and add output Parity_Err, 1 bit, asserted with R_Valid when any read byte mismatches.
REQ-034 Without DATA_MEM_PARITY_EN, the block SHALL have no parity storage and no Parity_Err port.

Structure
REQ-035 Package data_mem_pkg SHALL hold the FSM state enum and the four pattern byte constants (FF, 00, F0, AA).
REQ-036 The storage array SHALL be the sub-module data_mem_array: a synchronous 1-read/1-write RAM with byte enables, no reset on its contents.

Verification
REQ-037 Reset: release Rst, then count Busy-high cycles -> exactly 64; a read of address 63 returns 0x00000000.
REQ-038 Byte write: write 0x12345678 with Byte_En=0101 to address 5 over zeros, then read -> R_Data=0x00340078 one cycle later, R_Valid a single pulse.
REQ-039 Fill: Fill_Start with Pattern_Sel=10, wait for Busy low, read addresses 0 and 63 -> 0xF0F0F0F0; a write during Busy leaves the contents unchanged.
REQ-040 Same-address collision: address 9 holds 0xAAAAAAAA; read and write 0x11111111 to address 9 together -> R_Data=0xAAAAAAAA; the next read returns 0x11111111.
REQ-041 LED: read 0xF0F0A5C3, sweep Lane_Sel 0..3 -> LED=C3, A5, F0, F0.
REQ-042 Reset mid-fill: assert Rst at fill address 20 -> Busy stays high for 64 cycles after release and all words read 0.
